// File: rtl/cpu_mux_pkg.sv
// Shared definitions for the arb_mux_rr selector family.
//   MODE_FIXED : channel chosen by the explicit sel input
//   MODE_RR    : channel chosen by round-robin arbitration
package cpu_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder used by arb_mux_rr in round-robin mode.
// Ports:
//   req       : per-channel request vector
//   last      : index of the most recently served channel
//   en        : when low, no grant is produced
//   grant     : one-hot grant (all zero when nothing is granted)
//   grant_idx : binary index of the granted channel (0 when none)
// The search starts at last+1 and wraps modulo N, so the channel just
// served gets the lowest priority on the next evaluation.
module rr_arbiter #(
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  always_comb begin
    logic [SELW-1:0] ix;
    logic            found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    ix        = '0;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        ix = SELW'((int'(last) + k) % N);
        if (!found && req[ix]) begin
          found     = 1'b1;
          grant[ix] = 1'b1;
          grant_idx = ix;
        end
      end
    end
  end

endmodule

// File: rtl/arb_mux_rr.sv
// N-channel, WIDTH-bit multiplexer with a registered output stage.
// Channel choice is either the explicit sel input (mode=MODE_FIXED) or
// round-robin arbitration (mode=MODE_RR).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   mode, sel     : selection mode and fixed-mode channel index
//   in_data       : flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid      : per-channel valid
//   in_ready      : per-channel ready, at most one bit high
//   out_data      : registered selected word
//   out_valid     : out_data holds an unconsumed word
//   out_ready     : downstream accepts the word
//   out_sel       : channel that supplied out_data
//
// Handshake: a word moves across any interface on a rising edge where
// both valid and ready are high. Producers hold valid (and data) until
// that edge; ready may depend combinationally on valid, never the other
// way round. The output register accepts a new word whenever it is empty
// or being drained in the same cycle, so a continuous stream runs at one
// word per cycle with no bubbles.
module arb_mux_rr
  import cpu_mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
);

  logic [SELW-1:0]  last;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  grant_idx;
  logic [N-1:0]     rr_grant;
  logic [N-1:0]     fix_grant;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] sel_data;
  logic             load_en;
  logic             xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .last      (last),
    .en        (mode == MODE_RR),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // When N is not a power of two, sel can name a channel that does not
  // exist; such a select grants nothing.
  always_comb begin
    fix_grant = '0;
    if (int'(sel) < N) begin
      fix_grant[sel] = in_valid[sel];
    end
  end

  assign grant     = (mode == MODE_RR) ? rr_grant : fix_grant;
  assign grant_idx = (mode == MODE_RR) ? rr_idx   : sel;
  assign load_en   = !out_valid || out_ready;

  // Ready is held low while reset is asserted so nothing is accepted
  // from upstream even though the emptied register would allow it.
  assign in_ready  = (load_en && !rst) ? grant : '0;
  assign xfer      = |(in_valid & in_ready);
  assign sel_data  = in_data[int'(grant_idx)*WIDTH +: WIDTH];

  // The pointer follows every accepted transfer in either mode, so a
  // switch into round-robin continues after the channel served last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SELW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
      last      <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_rr.sv
module tb_arb_mux_rr;

  localparam int WIDTH = 32;
  localparam int N     = 8;
  localparam int SELW  = $clog2(N);
  localparam int N2    = 9;
  localparam int SELW2 = $clog2(N2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (N=8) ----------------
  logic               mode = 1'b0;
  logic [SELW-1:0]    sel = '0;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [N-1:0]       in_valid = '0;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [SELW-1:0]    out_sel;

  arb_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  // ---------------- second DUT (N=9, out-of-range select) ----------------
  logic                mode2 = 1'b0;
  logic [SELW2-1:0]    sel2 = '0;
  logic [N2*WIDTH-1:0] in_data2 = '0;
  logic [N2-1:0]       in_valid2 = '0;
  logic [N2-1:0]       in_ready2;
  logic [WIDTH-1:0]    out_data2;
  logic                out_valid2;
  logic                out_ready2 = 1'b1;
  logic [SELW2-1:0]    out_sel2;

  arb_mux_rr #(.WIDTH(WIDTH), .N(N2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode2),
    .sel       (sel2),
    .in_data   (in_data2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_sel   (out_sel2)
  );

  // ---------------- scoreboard / reference model ----------------
  int passed = 0;
  int total  = 0;
  logic [SELW+WIDTH-1:0] exp_q[$];
  logic m_valid = 1'b0;
  int   m_last  = N - 1;

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    int idx;
    g = '0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) g[sel] = 1'b1;
    end else begin
      for (int j = 1; j <= N; j++) begin
        idx = (m_last + j) % N;
        if (in_valid[idx]) begin
          g[idx] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = N - 1;
    exp_q.delete();
  endtask

  // One clock cycle: check ready against the model, retire a consumed
  // word from the queue, predict the next load, then advance the clock.
  task automatic step();
    logic [N-1:0] g;
    logic [SELW+WIDTH-1:0] e;
    int idx;
    #1;
    g = (!m_valid || out_ready) ? model_grant() : '0;
    total++;
    if (in_ready !== g) $display("FAIL step_in_ready: got %h expected %h", in_ready, g);
    else passed++;
    total++;
    if (out_valid !== m_valid) $display("FAIL step_out_valid: got %b expected %b", out_valid, m_valid);
    else passed++;
    if (m_valid && out_ready) begin
      e = exp_q.pop_front();
      total++;
      if ({out_sel, out_data} !== e)
        $display("FAIL scoreboard_word: got sel=%0d data=%h expected sel=%0d data=%h",
                 out_sel, out_data, e[SELW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
      else passed++;
    end
    if (g != '0) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (g[i]) idx = i;
      exp_q.push_back({SELW'(idx), in_data[idx*WIDTH +: WIDTH]});
      m_last  = idx;
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_pattern_data();
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'hDEAD0000 | i;
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mode     = 1'b1;
    in_valid = '1;
    load_pattern_data();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== '0) $display("FAIL reset_in_ready: got %h expected 0", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0)
      $display("FAIL reset_outputs: got v=%b d=%h s=%0d expected 0/0/0", out_valid, out_data, out_sel);
    else passed++;
    rst      = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if (out_data !== '0 || out_valid !== 1'b0)
        $display("FAIL idle_outputs: got v=%b d=%h expected 0/0", out_valid, out_data);
      else passed++;
    end
  endtask

  task automatic test_fixed();
    mode      = 1'b0;
    sel       = 3'd3;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    load_pattern_data();
    #1;
    total++;
    if (in_ready !== 8'h08) $display("FAIL fixed_in_ready: got %h expected 08", in_ready);
    else passed++;
    step();
    total++;
    if (out_data !== 32'hDEAD0003 || out_sel !== 3'd3 || out_valid !== 1'b1)
      $display("FAIL fixed_word: got d=%h s=%0d v=%b expected DEAD0003/3/1", out_data, out_sel, out_valid);
    else passed++;
    drain();
  endtask

  task automatic test_out_of_range();
    mode2      = 1'b0;
    sel2       = 4'd9;
    in_valid2  = '1;
    out_ready2 = 1'b1;
    for (int i = 0; i < N2; i++) in_data2[i*WIDTH +: WIDTH] = 32'hBEEF0000 | i;
    #1;
    total++;
    if (in_ready2 !== '0) $display("FAIL oor_in_ready: got %h expected 0", in_ready2);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (out_valid2 !== 1'b0) $display("FAIL oor_out_valid: got %b expected 0", out_valid2);
    else passed++;
    sel2 = 4'd8;
    #1;
    total++;
    if (in_ready2 !== 9'h100) $display("FAIL ch8_in_ready: got %h expected 100", in_ready2);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (out_valid2 !== 1'b1 || out_data2 !== 32'hBEEF0008 || out_sel2 !== 4'd8)
      $display("FAIL ch8_word: got v=%b d=%h s=%0d expected 1/BEEF0008/8", out_valid2, out_data2, out_sel2);
    else passed++;
    in_valid2 = '0;
  endtask

  task automatic test_rr_fairness();
    int seq[6] = '{0, 2, 7, 0, 2, 7};
    do_reset();
    mode      = 1'b1;
    in_valid  = 8'b1000_0101;
    out_ready = 1'b1;
    load_pattern_data();
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || int'(out_sel) != seq[k])
        $display("FAIL rr_seq[%0d]: got s=%0d v=%b expected s=%0d v=1", k, out_sel, out_valid, seq[k]);
      else passed++;
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    mode      = 1'b1;
    in_valid  = 8'b1000_0101;
    out_ready = 1'b1;
    load_pattern_data();
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      // Disturb the selection controls mid-stall; the held word must not move.
      if (c == 2) begin mode = 1'b0; sel = 3'd5; end
      if (c == 4) mode = 1'b1;
      step();
      total++;
      if (out_data !== 32'hDEAD0000 || out_sel !== 3'd0 || in_ready !== '0)
        $display("FAIL stall_hold: got d=%h s=%0d rdy=%h expected DEAD0000/0/00", out_data, out_sel, in_ready);
      else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 8'h04) $display("FAIL stall_release_grant: got %h expected 04", in_ready);
    else passed++;
    step();
    total++;
    if (out_sel !== 3'd2) $display("FAIL stall_next_sel: got %0d expected 2", out_sel);
    else passed++;
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    mode      = 1'b1;
    in_valid  = 8'h80;
    out_ready = 1'b1;
    load_pattern_data();
    #1;
    total++;
    if (in_ready !== 8'h80) $display("FAIL wrap_first_grant: got %h expected 80", in_ready);
    else passed++;
    step();
    in_valid = 8'h81;
    #1;
    total++;
    if (in_ready !== 8'h01) $display("FAIL wrap_second_grant: got %h expected 01", in_ready);
    else passed++;
    step();
    total++;
    if (out_sel !== 3'd0) $display("FAIL wrap_out_sel: got %0d expected 0", out_sel);
    else passed++;
    drain();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = SELW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom_range(0, (1 << N) - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
      step();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    mode      = 1'b1;
    in_valid  = 8'h04;
    out_ready = 1'b1;
    load_pattern_data();
    step();
    out_ready = 1'b0;
    in_valid  = '0;
    step();
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b expected 0", out_valid);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    in_valid  = 8'b1000_0001;
    out_ready = 1'b1;
    step();
    total++;
    if (out_sel !== 3'd0 || out_valid !== 1'b1)
      $display("FAIL post_reset_grant: got s=%0d v=%b expected 0/1", out_sel, out_valid);
    else passed++;
    drain();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_out_of_range();
    test_rr_fairness();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
